// File: rtl/sw_debounce_if.sv
// Switch-channel bundle between the debouncer and its user.
//   sw_in   : raw asynchronous switch pins (into the debouncer)
//   sw_db   : debounced level per channel
//   sw_rise : one-cycle pulse when sw_db goes 0->1
//   sw_fall : one-cycle pulse when sw_db goes 1->0
//   sw_tgl  : per-channel toggle state, flips on each sw_rise (0 when disabled)
// Modports: master drives sw_in, slave is the debouncer.
interface sw_debounce_if #(
  parameter int unsigned N_SW = 3
);
  logic [N_SW-1:0] sw_in;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic [N_SW-1:0] sw_tgl;

  modport master (
    output sw_in,
    input  sw_db,
    input  sw_rise,
    input  sw_fall,
    input  sw_tgl
  );

  modport slave (
    input  sw_in,
    output sw_db,
    output sw_rise,
    output sw_fall,
    output sw_tgl
  );
endinterface

// File: rtl/sw_debounce.sv
// Slide-switch debouncer: per channel a 2-FF synchroniser followed by a
// stable-time counter FSM. Produces a clean level plus registered one-cycle
// rise/fall pulses, all in the ck domain.
// Ports:
//   ck   : system clock, rising edge
//   rs_n : asynchronous active-low reset
//   sw   : sw_debounce_if slave (sw_in in; sw_db, sw_rise, sw_fall, sw_tgl out)
// Parameters:
//   N_SW       : number of independent channels
//   STABLE_CYC : consecutive differing cycles needed to flip the level (2..2^CNT_W)
//   CNT_W      : per-channel counter width, must hold STABLE_CYC-1
// Optional feature: define SW_DEBOUNCE_TOGGLE_EN to build the toggle flops;
// otherwise sw_tgl is tied to 0.
module sw_debounce #(
  parameter int unsigned N_SW       = 3,
  parameter int unsigned STABLE_CYC = 500000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic           ck,
  input  logic           rs_n,
  sw_debounce_if.slave   sw
);

  // Bit 1 of the encoding is the debounced level.
  typedef enum logic [1:0] {
    StStableLo = 2'b00,
    StWaitHi   = 2'b01,
    StStableHi = 2'b10,
    StWaitLo   = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [N_SW-1:0]  s1_q, s2_q;
  logic [N_SW-1:0]  rise_q, rise_d;
  logic [N_SW-1:0]  fall_q, fall_d;
  logic [N_SW-1:0]  db;
  state_e           state_q [N_SW];
  state_e           state_d [N_SW];
  logic [CNT_W-1:0] cnt_q   [N_SW];
  logic [CNT_W-1:0] cnt_d   [N_SW];

  // Synchroniser; only s2 feeds the FSMs.
  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw.sw_in;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      for (int i = 0; i < int'(N_SW); i++) begin
        state_q[i] <= StStableLo;
        cnt_q[i]   <= '0;
      end
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_SW); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  always_comb begin
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StStableLo: begin
          if (s2_q[i]) begin
            state_d[i] = StWaitHi;
            cnt_d[i]   = CntOne;
          end else begin
            cnt_d[i] = '0;
          end
        end
        StWaitHi: begin
          // Any reversion restarts the count from scratch.
          if (!s2_q[i]) begin
            state_d[i] = StStableLo;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StStableHi;
            cnt_d[i]   = '0;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StStableHi: begin
          if (!s2_q[i]) begin
            state_d[i] = StWaitLo;
            cnt_d[i]   = CntOne;
          end else begin
            cnt_d[i] = '0;
          end
        end
        StWaitLo: begin
          if (s2_q[i]) begin
            state_d[i] = StStableHi;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntLast) begin
            state_d[i] = StStableLo;
            cnt_d[i]   = '0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StStableLo;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    db = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      db[i] = state_q[i][1];
    end
  end

  assign sw.sw_db   = db;
  assign sw.sw_rise = rise_q;
  assign sw.sw_fall = fall_q;

`ifdef SW_DEBOUNCE_TOGGLE_EN
  // Flips on the same edge that raises sw_rise, so it is seen with the pulse.
  logic [N_SW-1:0] tgl_q;

  always_ff @(posedge ck or negedge rs_n) begin
    if (!rs_n) begin
      tgl_q <= '0;
    end else begin
      tgl_q <= tgl_q ^ rise_d;
    end
  end

  assign sw.sw_tgl = tgl_q;
`else
  assign sw.sw_tgl = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with N_SW=3, STABLE_CYC=8.
// Stimulus pushes each expected pulse (edge number, rise, fall, level, toggle)
// into a queue; a monitor pops one entry per observed pulse and compares.
module tb_sw_debounce;

  localparam int unsigned NSw    = 3;
  localparam int unsigned Stable = 8;
  localparam int unsigned Lat    = Stable + 1;  // edges after E1 until the flip

  typedef struct packed {
    logic [31:0] at;
    logic [2:0]  rise;
    logic [2:0]  fall;
    logic [2:0]  db;
    logic [2:0]  tgl;
  } ev_t;

  logic        ck;
  logic        rs_n;
  logic [31:0] cyc;
  int          n_checks;
  int          n_pass;
  ev_t         q[$];
  ev_t         mon_e;
  logic [2:0]  exp_db;
  logic [2:0]  exp_tgl;
  logic        tgl_en;
  logic [31:0] c;

  sw_debounce_if #(.N_SW(NSw)) bus ();

  sw_debounce #(
    .N_SW      (NSw),
    .STABLE_CYC(Stable),
    .CNT_W     (4)
  ) dut (
    .ck  (ck),
    .rs_n(rs_n),
    .sw  (bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial cyc = '0;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic waitn(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic model_reset();
    exp_db  = '0;
    exp_tgl = '0;
  endtask

  task automatic expect_ev(input logic [31:0] at, input logic [2:0] r, input logic [2:0] f);
    ev_t e;
    exp_db = (exp_db | r) & ~f;
    if (tgl_en) exp_tgl = exp_tgl ^ r;
    e.at   = at;
    e.rise = r;
    e.fall = f;
    e.db   = exp_db;
    e.tgl  = exp_tgl;
    q.push_back(e);
  endtask

  // Monitor: every observed pulse must match the oldest expected entry.
  always @(negedge ck) begin
    if (rs_n && ((bus.sw_rise | bus.sw_fall) != 3'b000)) begin
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_pulse: edge %0d rise=%b fall=%b db=%b, none expected",
                 cyc, bus.sw_rise, bus.sw_fall, bus.sw_db);
      end else begin
        mon_e = q.pop_front();
        if (cyc == mon_e.at && bus.sw_rise == mon_e.rise && bus.sw_fall == mon_e.fall &&
            bus.sw_db == mon_e.db && bus.sw_tgl == mon_e.tgl) begin
          n_pass++;
        end else begin
          $display("FAIL pulse: got edge %0d rise=%b fall=%b db=%b tgl=%b, expected edge %0d rise=%b fall=%b db=%b tgl=%b",
                   cyc, bus.sw_rise, bus.sw_fall, bus.sw_db, bus.sw_tgl,
                   mon_e.at, mon_e.rise, mon_e.fall, mon_e.db, mon_e.tgl);
        end
      end
    end
  end

  initial begin
    logic [2:0] exp_t;
    n_checks = 0;
    n_pass   = 0;
`ifdef SW_DEBOUNCE_TOGGLE_EN
    tgl_en = 1'b1;
`else
    tgl_en = 1'b0;
`endif
    model_reset();
    rs_n      = 1'b0;
    bus.sw_in = 3'b000;
    waitn(3);
    check("reset_db",   {29'd0, bus.sw_db},   32'd0);
    check("reset_rise", {29'd0, bus.sw_rise}, 32'd0);
    check("reset_fall", {29'd0, bus.sw_fall}, 32'd0);
    check("reset_tgl",  {29'd0, bus.sw_tgl},  32'd0);
    rs_n = 1'b1;
    waitn(3);

    // Clean rise and fall on channel 0.
    bus.sw_in = 3'b001;
    c = cyc + 1;
    expect_ev(c + Lat, 3'b001, 3'b000);
    waitn(12);
    check("clean_rise_db", {29'd0, bus.sw_db}, 32'd1);
    bus.sw_in = 3'b000;
    c = cyc + 1;
    expect_ev(c + Lat, 3'b000, 3'b001);
    waitn(12);
    check("clean_fall_db", {29'd0, bus.sw_db}, 32'd0);

    // Bounce on channel 1: 3-cycle segments never reach the threshold.
    for (int k = 0; k < 10; k++) begin
      bus.sw_in[1] = (k % 2 == 0);
      waitn(3);
    end
    check("bounce_quiet_db", {29'd0, bus.sw_db}, 32'd0);
    bus.sw_in[1] = 1'b1;
    c = cyc + 1;
    expect_ev(c + Lat, 3'b010, 3'b000);
    waitn(12);
    check("bounce_settle_db", {29'd0, bus.sw_db}, 32'd2);
    bus.sw_in[1] = 1'b0;
    c = cyc + 1;
    expect_ev(c + Lat, 3'b000, 3'b010);
    waitn(12);

    // Glitch threshold on channel 2: 7 cycles filtered, 8 cycles pass.
    bus.sw_in[2] = 1'b1;
    waitn(7);
    bus.sw_in[2] = 1'b0;
    waitn(12);
    check("glitch7_db", {29'd0, bus.sw_db}, 32'd0);
    bus.sw_in[2] = 1'b1;
    c = cyc + 1;
    expect_ev(c + Lat, 3'b100, 3'b000);
    waitn(8);
    bus.sw_in[2] = 1'b0;
    expect_ev(c + 8 + Lat, 3'b000, 3'b100);
    waitn(14);
    check("glitch8_db", {29'd0, bus.sw_db}, 32'd0);

    // Simultaneous channels 0 and 2.
    bus.sw_in = 3'b101;
    c = cyc + 1;
    expect_ev(c + Lat, 3'b101, 3'b000);
    waitn(12);
    check("simul_rise_db", {29'd0, bus.sw_db}, 32'd5);
    bus.sw_in = 3'b000;
    c = cyc + 1;
    expect_ev(c + Lat, 3'b000, 3'b101);
    waitn(12);

    // Reset after 5 counting edges discards progress.
    bus.sw_in = 3'b101;
    waitn(7);
    rs_n = 1'b0;
    model_reset();
    #1;
    check("midcount_reset_db", {29'd0, bus.sw_db}, 32'd0);
    waitn(2);
    rs_n = 1'b1;
    c = cyc + 1;
    expect_ev(c + Lat, 3'b101, 3'b000);
    waitn(12);
    check("midcount_after_db", {29'd0, bus.sw_db}, 32'd5);

    // Asynchronous reset between edges while all channels are high.
    bus.sw_in = 3'b111;
    c = cyc + 1;
    expect_ev(c + Lat, 3'b010, 3'b000);
    waitn(12);
    check("all_high_db", {29'd0, bus.sw_db}, 32'd7);
    @(posedge ck);
    #2;
    rs_n = 1'b0;
    model_reset();
    #1;
    check("async_db",   {29'd0, bus.sw_db},   32'd0);
    check("async_rise", {29'd0, bus.sw_rise}, 32'd0);
    check("async_fall", {29'd0, bus.sw_fall}, 32'd0);
    check("async_tgl",  {29'd0, bus.sw_tgl},  32'd0);
    waitn(2);
    rs_n = 1'b1;
    c = cyc + 1;
    expect_ev(c + Lat, 3'b111, 3'b000);
    waitn(12);
    check("release_db", {29'd0, bus.sw_db}, 32'd7);

    // Toggle: three clean presses on channel 0 from a fresh reset.
    bus.sw_in = 3'b000;
    rs_n = 1'b0;
    model_reset();
    waitn(2);
    rs_n = 1'b1;
    waitn(3);
    for (int k = 0; k < 3; k++) begin
      bus.sw_in = 3'b001;
      c = cyc + 1;
      expect_ev(c + Lat, 3'b001, 3'b000);
      waitn(12);
      exp_t = (tgl_en && (k % 2 == 0)) ? 3'b001 : 3'b000;
      check("tgl_press", {29'd0, bus.sw_tgl}, {29'd0, exp_t});
      bus.sw_in = 3'b000;
      c = cyc + 1;
      expect_ev(c + Lat, 3'b000, 3'b001);
      waitn(12);
    end

    waitn(2);
    while (q.size() != 0) begin
      mon_e = q.pop_front();
      n_checks++;
      $display("FAIL missing_pulse: got nothing, expected edge %0d rise=%b fall=%b",
               mon_e.at, mon_e.rise, mon_e.fall);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
